// File: rtl/rv32_pkg.sv
// Shared RV32 front-end constants used by the fetch unit and its buffers.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
  localparam int FETCH_DEPTH = 2;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with a flush that empties it in one cycle.
// Pop on empty and push on full (without a same-cycle pop) are ignored.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    do_pop   = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches, pairs in-order
// responses with their PCs and buffers {pc,instr} toward decode; redirects flush.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter int              XLEN     = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv32_pkg::RESET_PC,
  parameter int              DEPTH    = FETCH_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);
  // Both channels are strict valid/ready: a transfer happens on a rising edge
  // where valid && ready; a stalled request holds its address (only a redirect
  // may replace it), and responses carry no ready since credits bound them.
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = XLEN + INSTR_W;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   kill_q, kill_d;
  logic [CW-1:0]   pcq_count, buf_count, outstanding_next;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] pcq_head;
  logic [BW-1:0]   buf_head;
  logic            pcq_empty, pcq_full, buf_empty, buf_full;
  logic            req_accept, rsp_keep, out_fire;

  // Outstanding fetches are exactly the occupancy of the in-flight PC queue.
  always_comb begin
    credit_used    = {1'b0, pcq_count} + {1'b0, buf_count};
    imem_req_valid = !rst && (credit_used < (CW+1)'(DEPTH));
    imem_req_addr  = pc_q;
    req_accept     = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && (kill_q == '0) && !redirect_valid;
    out_valid      = !rst && !buf_empty;
    out_fire       = out_valid && out_ready;
    out_pc         = buf_head[BW-1 -: XLEN];
    out_instr      = out_valid ? buf_head[INSTR_W-1:0] : NOP;
  end

  always_comb begin
    outstanding_next = pcq_count + CW'(req_accept) - CW'(imem_rsp_valid);
    pc_d   = pc_q;
    kill_d = kill_q;
    if (req_accept) begin
      pc_d = pc_q + XLEN'(4);
    end
    if (imem_rsp_valid && (kill_q != '0)) begin
      kill_d = kill_q - CW'(1);
    end
    // Everything still in flight after this cycle predates the redirect.
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~XLEN'(3);
      kill_d = outstanding_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      kill_q <= '0;
    end else begin
      pc_q   <= pc_d;
      kill_q <= kill_d;
    end
  end

  fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_accept),
    .push_data (pc_q),
    .pop       (imem_rsp_valid),
    .head      (pcq_head),
    .count     (pcq_count),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  fetch_fifo #(.W(BW), .DEPTH(DEPTH)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({pcq_head, imem_rsp_data}),
    .pop       (out_fire),
    .head      (buf_head),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (imem_rsp_valid) assert (!pcq_empty);
      if (req_accept) assert (!pcq_full);
      if (rsp_keep) assert (!buf_full || out_fire);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-modelled memory, expected-PC scoreboard,
// decoupled output monitor.
module tb_fetch_unit;
  // DEPTH 4 lets the credit rule sustain one delivery per cycle at latency 1.
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          deliv_cnt = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  logic [31:0] exp_q[$];
  logic [31:0] acc_addr_q[$];
  int          acc_cyc_q[$];
  int          del_cyc_q[$];
  pend_t       pend_q[$];

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- instruction memory model ----------------
  // Inputs change on the falling edge; a response is due lat cycles after accept.
  always @(negedge clk) begin
    pend_t p;
    int    due;
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (rst) begin
      pend_q.delete();
      last_due = cyc;
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        p.addr = imem_req_addr;
        p.due  = due;
        pend_q.push_back(p);
        acc_addr_q.push_back(imem_req_addr);
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (out_valid && out_ready) begin
      deliv_cnt++;
      del_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got pc %h, required no delivery", out_pc);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_instr", out_instr, mem_word(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    acc_addr_q.delete();
    acc_cyc_q.delete();
    del_cyc_q.delete();
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Returns at a falling edge with out_ready dropped after exactly n deliveries.
  task automatic wait_deliv(input int n, input bit rand_ready);
    int start;
    int budget;
    start  = deliv_cnt;
    budget = 400;
    while (deliv_cnt - start < n && budget > 0) begin
      @(negedge clk);
      if (rand_ready) imem_req_ready = 1'($urandom_range(0, 1));
      budget--;
    end
    out_ready = 1'b0;
    check("deliv_count", 32'(deliv_cnt - start), 32'(n));
  endtask

  // Redirect with everything stalled, then idle until stale responses drain.
  task automatic settle(input logic [31:0] a);
    @(negedge clk);
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = a;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (8) @(negedge clk);
    clear_logs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b;
    int pre;

    // Reset
    @(negedge clk);
    #2;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat = 1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    clear_logs();
    #2;
    check("first_req_valid", 32'(imem_req_valid), 32'h1);
    check("first_req_addr", imem_req_addr, 32'h0);
    check("first_out_valid", 32'(out_valid), 32'h0);

    // 1: latency 1, streaming 0,4,8,12
    push_seq(32'h0, 4);
    wait_deliv(4, 1'b0);
    check("t1_del_count", 32'(del_cyc_q.size()), 32'd4);
    if (del_cyc_q.size() >= 4 && acc_cyc_q.size() >= 1) begin
      check("t1_first_latency", 32'(del_cyc_q[0] - acc_cyc_q[0]), 32'd2);
      for (int i = 1; i < 4; i++) check("t1_one_per_cycle", 32'(del_cyc_q[i] - del_cyc_q[i-1]), 32'd1);
    end

    // 2: decode stalled 10 cycles -> exactly DEPTH fetches, then release
    settle(32'h200);
    lat = 1;
    imem_req_ready = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    check("t2_accepts", 32'(acc_addr_q.size()), 32'(DEPTH));
    check("t2_req_valid_low", 32'(imem_req_valid), 32'h0);
    for (int i = 0; i < acc_addr_q.size() && i < DEPTH; i++)
      check("t2_acc_addr", acc_addr_q[i], 32'h200 + 32'(4 * i));
    push_seq(32'h200, 8);
    out_ready = 1'b1;
    wait_deliv(8, 1'b0);

    // 3: latency 3, two outstanding, redirect to 0x100
    settle(32'h300);
    lat = 3;
    imem_req_ready = 1'b1;
    b = 50;
    while (acc_addr_q.size() < 2 && b > 0) begin
      @(negedge clk);
      b--;
    end
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    out_ready      = 1'b1;
    check("t3_outstanding", 32'(acc_addr_q.size()), 32'd2);
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    clear_logs();
    push_seq(32'h100, 3);
    wait_deliv(3, 1'b0);
    if (acc_addr_q.size() > 0) check("t3_first_addr", acc_addr_q[0], 32'h100);

    // 4: redirect in the same cycle as an accept and a live response
    settle(32'h400);
    lat = 2;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    #2;
    check("t4_accept_same_cycle", 32'(imem_req_valid && imem_req_ready), 32'h1);
    check("t4_rsp_same_cycle", 32'(imem_rsp_valid), 32'h1);
    @(negedge clk);
    redirect_valid = 1'b0;
    push_seq(32'h500, 3);
    wait_deliv(3, 1'b0);

    // 5: unaligned redirect near the top of memory, PC wraps
    settle(32'hFFFF_FFFE);
    lat = 1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    wait_deliv(3, 1'b0);
    check("t5_acc_count", 32'(acc_addr_q.size() >= 2), 32'h1);
    if (acc_addr_q.size() >= 2) begin
      check("t5_addr_top", acc_addr_q[0], 32'hFFFF_FFFC);
      check("t5_addr_wrap", acc_addr_q[1], 32'h0);
    end

    // 6: random request stalls, reset mid-stream
    settle(32'h600);
    lat = 2;
    out_ready = 1'b1;
    push_seq(32'h600, 64);
    pre = deliv_cnt;
    repeat (24) begin
      @(negedge clk);
      imem_req_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    check("t6_pre_rst_delivered", 32'(deliv_cnt - pre >= 2), 32'h1);
    #2;
    check("t6_rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("t6_rst_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    #2;
    check("t6_rst2_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    push_seq(32'h0, 8);
    #2;
    check("t6_restart_addr", imem_req_addr, 32'h0);
    check("t6_restart_out_valid", 32'(out_valid), 32'h0);
    wait_deliv(8, 1'b1);
    if (acc_addr_q.size() > 0) check("t6_first_acc", acc_addr_q[0], 32'h0);

    repeat (10) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
